dram_rd_responder: RTL and testbench

Synthesizable DRAM read-side responder that serves instruction-cache line fills. It sits on the cache's DRAM read port (dram_rd_req / dram_rd_address / dram_rd_vld / dram_rd_data) and answers each request with a fixed-latency, critical-word-first burst of one cache line, read from an internal word memory. It replaces the behavioural DRAM model in system simulation and also runs on FPGA. A side load port fills the memory before the CPU is enabled.

---
 rtl/dram_pkg.sv | 21 ++
 rtl/dram_word_ram.sv | 38 +++
 rtl/dram_rd_responder.sv | 137 +++++++++++++
 tb/tb_dram_rd_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared DRAM definitions for the read responder and the I-cache fill logic.
//   - dram_state_t : responder FSM encoding
//   - dram_off_w() : bit width of a word offset inside a cache line
//   - DRAM_DATA_W / DRAM_ADDR_W : default data-word and byte-address widths
package dram_pkg;

    localparam int DRAM_DATA_W = 32;
    localparam int DRAM_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_BURST   = 2'd2,
        ST_RELEASE = 2'd3
    } dram_state_t;

    function automatic int dram_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/dram_word_ram.sv
// Word memory behind the DRAM read responder.
//   clock, rst_n      : clock, async active-low reset (read register only)
//   we/wr_addr/wr_data: synchronous write port (load port)
//   rd_en/rd_addr     : read request, sampled at the clock edge
//   rd_data           : registered read data, holds its value when rd_en=0
// The array itself is never reset, so contents survive rst_n. A read and a
// write of the same word at the same edge return the old word.
module dram_word_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dram_rd_responder.sv
// DRAM read-side responder for instruction-cache line fills.
//   clock, rst_n        : clock, async active-low reset
//   dram_rd_req         : level request, held until the last beat is taken
//   dram_rd_address     : byte address of the missed word
//   dram_rd_vld         : registered beat valid
//   dram_rd_data        : registered beat data (holds last beat otherwise)
//   busy                : high whenever the FSM is not idle
//   load_en/addr/data   : memory preload write port, usable in any state
// Each accepted request yields LINE_WORDS beats, critical word first and
// wrapping inside the line, the first one LATENCY cycles after acceptance.
module dram_rd_responder
    import dram_pkg::*;
#(
    parameter int DATA_W     = DRAM_DATA_W,
    parameter int ADDR_W     = DRAM_ADDR_W,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 8,
    parameter int MEM_AW     = 10
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              dram_rd_req,
    input  logic [ADDR_W-1:0] dram_rd_address,
    output logic              dram_rd_vld,
    output logic [DATA_W-1:0] dram_rd_data,
    output logic              busy,
    input  logic              load_en,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    localparam int OFF_W = dram_off_w(LINE_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dram_state_t       state, state_nxt;
    logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic [OFF_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [OFF_W-1:0]  offset, offset_nxt;
    logic [OFF_W-1:0]  issue_beat;
    logic [OFF_W-1:0]  beat_sel;
    logic [MEM_AW-1:0] line_base, line_base_nxt;
    logic [MEM_AW-1:0] word_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic              rd_en;
    logic              unused_addr_bits;

    // Bits above the memory size alias; the byte lane bits are irrelevant.
    assign word_idx         = dram_rd_address[MEM_AW+1:2];
    assign unused_addr_bits = ^{dram_rd_address[ADDR_W-1:MEM_AW+2], dram_rd_address[1:0]};

    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        beat_cnt_nxt  = beat_cnt;
        offset_nxt    = offset;
        line_base_nxt = line_base;
        rd_en         = 1'b0;
        issue_beat    = '0;
        case (state)
            ST_IDLE: begin
                if (dram_rd_req) begin
                    line_base_nxt = {word_idx[MEM_AW-1:OFF_W], {OFF_W{1'b0}}};
                    offset_nxt    = word_idx[OFF_W-1:0];
                    lat_cnt_nxt   = CNT_W'(LATENCY - 1);
                    state_nxt     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    // Read is issued one cycle early so data lands with vld.
                    rd_en        = 1'b1;
                    issue_beat   = '0;
                    beat_cnt_nxt = '0;
                    state_nxt    = ST_BURST;
                end else begin
                    lat_cnt_nxt = lat_cnt - CNT_W'(1);
                end
            end
            ST_BURST: begin
                // beat_cnt is the beat currently on the outputs.
                if (beat_cnt == OFF_W'(LINE_WORDS - 1)) begin
                    state_nxt = ST_RELEASE;
                end else begin
                    rd_en        = 1'b1;
                    issue_beat   = beat_cnt + OFF_W'(1);
                    beat_cnt_nxt = beat_cnt + OFF_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!dram_rd_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Offset arithmetic truncates to OFF_W bits: wrap stays inside the line.
    assign beat_sel = offset + issue_beat;
    assign rd_idx   = line_base | {{(MEM_AW-OFF_W){1'b0}}, beat_sel};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            beat_cnt    <= '0;
            dram_rd_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            lat_cnt     <= lat_cnt_nxt;
            beat_cnt    <= beat_cnt_nxt;
            dram_rd_vld <= rd_en;
        end
    end

    always_ff @(posedge clock) begin
        line_base <= line_base_nxt;
        offset    <= offset_nxt;
    end

    assign busy = (state != ST_IDLE);

    dram_word_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clock   (clock),
        .rst_n   (rst_n),
        .we      (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (rd_idx),
        .rd_data (dram_rd_data)
    );

endmodule

// File: tb/tb_dram_rd_responder.sv
// Directed bench for dram_rd_responder (LINE_WORDS=4, LATENCY=8, MEM_AW=10).
module tb_dram_rd_responder;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int LATENCY    = 8;
    localparam int MEM_AW     = 10;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              dram_rd_req;
    logic [ADDR_W-1:0] dram_rd_address;
    logic              dram_rd_vld;
    logic [DATA_W-1:0] dram_rd_data;
    logic              busy;
    logic              load_en;
    logic [MEM_AW-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    dram_rd_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .LATENCY    (LATENCY),
        .MEM_AW     (MEM_AW)
    ) dut (
        .clock           (clock),
        .rst_n           (rst_n),
        .dram_rd_req     (dram_rd_req),
        .dram_rd_address (dram_rd_address),
        .dram_rd_vld     (dram_rd_vld),
        .dram_rd_data    (dram_rd_data),
        .busy            (busy),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [MEM_AW-1:0] a, input logic [DATA_W-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    // Request one line and check acceptance, the silent wait and every beat.
    // coll_beat >= 0 writes 0xDEAD to coll_addr at the edge producing that beat.
    task automatic do_burst(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3,
                            input int coll_beat, input logic [MEM_AW-1:0] coll_addr);
        logic [DATA_W-1:0] exp_q [4];
        exp_q = '{e0, e1, e2, e3};
        dram_rd_req     = 1'b1;
        dram_rd_address = addr;
        step();
        chk({tag, "_busy_acc"}, 64'(busy), 64'd1);
        chk({tag, "_vld_acc"}, 64'(dram_rd_vld), 64'd0);
        // Address changes after acceptance must be ignored.
        dram_rd_address = 32'hFFFF_FFFC;
        for (int j = 1; j < LATENCY; j++) begin
            step();
            chk({tag, "_wait_vld"}, 64'(dram_rd_vld), 64'd0);
        end
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (i == coll_beat) begin
                load_en   = 1'b1;
                load_addr = coll_addr;
                load_data = 32'h0000_DEAD;
            end
            step();
            load_en = 1'b0;
            chk({tag, "_beat_vld"}, 64'(dram_rd_vld), 64'd1);
            chk({tag, "_beat_data"}, 64'(dram_rd_data), 64'(exp_q[i]));
        end
    endtask

    // Keep req high for 'hold' extra cycles in RELEASE, then drop it.
    task automatic release_req(input string tag, input int hold, input logic [DATA_W-1:0] last);
        step();
        chk({tag, "_rel_vld"}, 64'(dram_rd_vld), 64'd0);
        chk({tag, "_rel_busy"}, 64'(busy), 64'd1);
        chk({tag, "_rel_data_hold"}, 64'(dram_rd_data), 64'(last));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_held_vld"}, 64'(dram_rd_vld), 64'd0);
            chk({tag, "_held_busy"}, 64'(busy), 64'd1);
        end
        dram_rd_req = 1'b0;
        step();
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_vld"}, 64'(dram_rd_vld), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        dram_rd_req     = 1'b0;
        dram_rd_address = '0;
        load_en         = 1'b0;
        load_addr       = '0;
        load_data       = '0;
        #2;
        chk("reset_vld", 64'(dram_rd_vld), 64'd0);
        chk("reset_data", 64'(dram_rd_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        for (int w = 0; w < 4; w++) begin
            load_word(MEM_AW'(10'h40 + w), 32'hA0 + w);
        end

        do_burst("aln", 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, '0);
        release_req("aln", 0, 32'hA3);

        do_burst("cwf", 32'h108, 32'hA2, 32'hA3, 32'hA0, 32'hA1, -1, '0);
        release_req("cwf", 0, 32'hA1);

        do_burst("hld", 32'h10C, 32'hA3, 32'hA0, 32'hA1, 32'hA2, -1, '0);
        release_req("hld", 5, 32'hA2);
        do_burst("b2b", 32'h104, 32'hA1, 32'hA2, 32'hA3, 32'hA0, -1, '0);
        release_req("b2b", 0, 32'hA0);

        do_burst("als", 32'h1000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, '0);
        release_req("als", 0, 32'hA3);

        do_burst("col", 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 10'h41);
        release_req("col", 0, 32'hA3);
        do_burst("rpt", 32'h104, 32'h0000_DEAD, 32'hA2, 32'hA3, 32'hA0, -1, '0);
        release_req("rpt", 0, 32'hA0);
        load_word(10'h41, 32'hA1);

        // Reset in the middle of a burst.
        dram_rd_req     = 1'b1;
        dram_rd_address = 32'h100;
        for (int j = 0; j < LATENCY + 2; j++) begin
            step();
        end
        chk("mid_burst_vld", 64'(dram_rd_vld), 64'd1);
        #2;
        rst_n       = 1'b0;
        dram_rd_req = 1'b0;
        #1;
        chk("async_rst_vld", 64'(dram_rd_vld), 64'd0);
        chk("async_rst_data", 64'(dram_rd_data), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            chk("post_rst_vld", 64'(dram_rd_vld), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        do_burst("post", 32'h100, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, '0);
        release_req("post", 0, 32'hA3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
